// File: rtl/led_arbiter.sv
// led_arbiter: fixed-priority owner selection for a single RGB LED.
// A new owner's colour stays on the LED for a minimum hold time.
// If it releases early, the last colour is kept frozen until the hold expires.
// Optional feature macro: LED_ARB_PREEMPT_EN. When it is defined, a
// higher-priority request may take the LED from its owner once the hold
// has expired.
module led_arbiter #(
  parameter int TANG_NANO_HZ = 24_000_000,
  parameter int TICK_HZ      = 100,
  parameter int HOLD_TICKS   = 50
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] color0,
  input  logic [2:0] color1,
  input  logic [2:0] color2,
  output logic [2:0] gnt,
  output logic [2:0] led,
  output logic       busy
);

  localparam int TICK_DIV = TANG_NANO_HZ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);
  localparam int HW       = $clog2(HOLD_TICKS + 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

  typedef enum logic [1:0] {IDLE, OWNED, LINGER} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   pre_reg;
  logic            tick;
  logic [HW-1:0]   hold_reg, hold_next;
  logic            hold_done;
  logic [2:0]      gnt_reg, gnt_next;
  logic [2:0]      led_reg, led_next;
  logic            busy_reg;
  logic            new_grant;
  logic [2:0]      win;
  logic [2:0]      win_color, own_color;
  logic [2:0]      color_arr [3];
  logic [2:0]      win_term  [3];
  logic [2:0]      own_term  [3];

  assign color_arr[0] = color0;
  assign color_arr[1] = color1;
  assign color_arr[2] = color2;

  // Lowest set request bit, as a one-hot vector (lowest index wins)
  assign win = req & (~req + 3'd1);

  // Gate each colour by the winner and the current owner. Both select
  // vectors are one-hot or zero, so OR-ing the terms forms a mux.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_color_sel
      assign win_term[gi] = color_arr[gi] & {3{win[gi]}};
      assign own_term[gi] = color_arr[gi] & {3{gnt_reg[gi]}};
    end
  endgenerate

  assign win_color = win_term[0] | win_term[1] | win_term[2];
  assign own_color = own_term[0] | own_term[1] | own_term[2];

  assign tick      = (pre_reg == PRE_MAX);
  assign hold_done = (hold_reg >= HOLD_MAX);

  // Free-running tick prescaler
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)       pre_reg <= '0;
    else if (tick) pre_reg <= '0;
    else           pre_reg <= pre_reg + 1'b1;
  end

  // Hold counter: restarts on each grant, counts ticks, saturates
  always_comb begin
    hold_next = hold_reg;
    if (new_grant)               hold_next = '0;
    else if (tick && !hold_done) hold_next = hold_reg + 1'b1;
  end

  // Next state, next grant and next LED value
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    led_next   = led_reg;
    new_grant  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        gnt_next = 3'b000;
        led_next = 3'b000;
        if (req != 3'b000) begin
          gnt_next   = win;
          led_next   = win_color;
          new_grant  = 1'b1;
          state_next = OWNED;
        end
      end
      OWNED: begin
        if ((req & gnt_reg) != 3'b000) begin
          led_next = own_color;
`ifdef LED_ARB_PREEMPT_EN
          // Owner still requests: a lower-index request outranks it once the hold is over
          if (hold_done && (win != gnt_reg)) begin
            gnt_next  = win;
            led_next  = win_color;
            new_grant = 1'b1;
          end
`endif
        end else if (hold_done) begin
          if (req != 3'b000) begin
            gnt_next  = win;
            led_next  = win_color;
            new_grant = 1'b1;
          end else begin
            gnt_next   = 3'b000;
            led_next   = 3'b000;
            state_next = IDLE;
          end
        end else begin
          // Early release: drop the grant and keep the last colour
          gnt_next   = 3'b000;
          state_next = LINGER;
        end
      end
      LINGER: begin
        gnt_next = 3'b000;
        if (hold_done) begin
          if (req != 3'b000) begin
            gnt_next   = win;
            led_next   = win_color;
            new_grant  = 1'b1;
            state_next = OWNED;
          end else begin
            led_next   = 3'b000;
            state_next = IDLE;
          end
        end
      end
      default: begin
        gnt_next   = 3'b000;
        led_next   = 3'b000;
        state_next = IDLE;
      end
    endcase
  end

  // State, hold and registered outputs
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      gnt_reg   <= 3'b000;
      led_reg   <= 3'b000;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      gnt_reg   <= gnt_next;
      led_reg   <= led_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  assign gnt  = gnt_reg;
  assign led  = led_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: directed and random stimulus for led_arbiter. The outputs
// are compared against an ownership/time model driven by edge counts.
module tb_led_arbiter;

  localparam int TN  = 100;
  localparam int TH  = 10;
  localparam int HT  = 3;
  localparam int DIV = TN / TH;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [2:0] req, color0, color1, color2;
  logic [2:0] gnt, led;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Model: owner index (-1 none), linger flag, displayed colour,
  // edge number since reset and edge number of the last grant.
  int         m_owner;
  bit         m_linger;
  logic [2:0] m_led;
  int         k;
  int         m_g;

  led_arbiter #(.TANG_NANO_HZ(TN), .TICK_HZ(TH), .HOLD_TICKS(HT)) dut (
    .sys_clk(sys_clk), .rst(rst), .req(req),
    .color0(color0), .color1(color1), .color2(color2),
    .gnt(gnt), .led(led), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int lowest(logic [2:0] r);
    for (int i = 0; i < 3; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [2:0] col(int i);
    case (i)
      0:       return color0;
      1:       return color1;
      default: return color2;
    endcase
  endfunction

  task automatic chk(string tag, logic [2:0] obs, logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0; m_g = 0; m_owner = -1; m_linger = 0; m_led = 3'b000;
  endtask

  task automatic m_grant(int w);
    m_owner = w; m_g = k; m_led = col(w); m_linger = 0;
  endtask

  task automatic m_idle();
    m_owner = -1; m_linger = 0; m_led = 3'b000;
  endtask

  // Apply one clock edge. Ticks occur on every DIV-th edge after reset.
  // The hold is over once HT ticks have fallen strictly after the grant edge
  // and strictly before the current edge.
  task automatic model_edge();
    int w;
    bit hd;
    k++;
    hd = (((k - 1) / DIV) - (m_g / DIV)) >= HT;
    w  = lowest(req);
    if (m_owner >= 0) begin
      if (req[m_owner]) begin
        m_led = col(m_owner);
`ifdef LED_ARB_PREEMPT_EN
        if (hd && w < m_owner) m_grant(w);
`endif
      end else if (hd) begin
        if (w >= 0) m_grant(w); else m_idle();
      end else begin
        m_owner = -1; m_linger = 1;
      end
    end else if (m_linger) begin
      if (hd) begin
        if (w >= 0) m_grant(w); else m_idle();
      end
    end else if (w >= 0) begin
      m_grant(w);
    end
  endtask

  task automatic check_all(string tag);
    logic [2:0] eg;
    eg = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".led"}, led, m_led);
    chk({tag, ".busy"}, {2'b00, busy}, {2'b00, (m_owner >= 0) || m_linger});
  endtask

  task automatic step(string tag);
    @(posedge sys_clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drain(string tag);
    req = 3'b000;
    for (int i = 0; i < 40 && busy === 1'b1; i++) step(tag);
    chk({tag, ".timeout"}, {2'b00, busy}, 3'b000);
  endtask

  initial begin
    int n;
    rst = 1'b1; req = 3'b000; color0 = 3'b000; color1 = 3'b000; color2 = 3'b000;
    model_reset();
    #12;
    check_all("reset");
    @(posedge sys_clk); #1; rst = 1'b0;

    // Single grant and colour tracking
    req = 3'b010; color1 = 3'b101;
    step("grant1");
    chk("grant1.explicit_led", led, 3'b101);
    color1 = 3'b011;
    step("color_track");
    chk("color_track.explicit_led", led, 3'b011);
    drain("drain1");

    // Simultaneous requests
    req = 3'b111; color0 = 3'b001; color1 = 3'b010; color2 = 3'b100;
    step("simul");
    chk("simul.explicit_gnt", gnt, 3'b001);
    drain("drain2");

    // Short request followed by linger
    req = 3'b001; color0 = 3'b100;
    step("pulse_grant");
    req = 3'b000;
    step("pulse_linger");
    n = 0;
    for (int i = 0; i < 40 && gnt === 3'b000 && led === 3'b100; i++) begin
      n++;
      step("linger");
    end
    total++;
    assert (n >= 21 && n <= 30) else begin
      bad++;
      $error("FAIL linger_len observed=%0d expected=21..30", n);
    end
    drain("drain3");

    // Preemption attempt after requester 2's hold has expired
    req = 3'b100; color2 = 3'b110; color0 = 3'b010;
    for (int i = 0; i < 35; i++) step("own2");
    req = 3'b101;
    step("preempt");
`ifdef LED_ARB_PREEMPT_EN
    chk("preempt.explicit_gnt", gnt, 3'b001);
`else
    chk("preempt.explicit_gnt", gnt, 3'b100);
`endif
    drain("drain4");

    // Reset during linger, checked before any further edge
    req = 3'b010; color1 = 3'b111;
    step("pre_rst_grant");
    req = 3'b000;
    step("pre_rst_linger");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge sys_clk); #1; rst = 1'b0;
    for (int i = 0; i < 5; i++) step("post_rst_idle");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) color0 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) color1 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) color2 = 3'($urandom_range(0, 7));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_arbiter.md
# led_arbiter

Arbitrates the board's single 3-bit RGB LED among three independent requesters, such as a heartbeat, a status/error indicator and a user pattern. It sits between those requesters and the LED pins and drives the LED directly. It grants the LED by fixed priority. Once granted, each owner's colour is held visible for a minimum time so that short requests still produce a perceivable flash and the colour does not flicker.

## Interface
Parameters:
- TANG_NANO_HZ, 24_000_000, sys_clk frequency in Hz.
- TICK_HZ, 100, hold-timer tick rate. TICK_DIV = TANG_NANO_HZ / TICK_HZ; TICK_DIV must be ≥ 2.
- HOLD_TICKS, 50, minimum display time in ticks; must be ≥ 1. The default gives 0.5 s.

Ports:
- sys_clk, input, 1, system clock.
- rst, input, 1, reset. Asynchronous, active-high.
- req, input, 3, request per requester. Bit 0 has the highest priority.
- color0, input, 3, RGB value of requester 0. Sampled live while owned.
- color1, input, 3, RGB value of requester 1.
- color2, input, 3, RGB value of requester 2.
- gnt, output reg, 3, one-hot grant; 000 means no owner.
- led, output reg, 3, LED drive. 000 means off.
- busy, output reg, 1, high when the FSM is not IDLE.

## Operation
Prescaler:
- Free-running counter from 0 to TICK_DIV-1, width $clog2(TICK_DIV).
- `tick` is a one-cycle pulse when the count equals TICK_DIV-1; the counter then wraps to 0.

Hold counter:
- Width $clog2(HOLD_TICKS+1).
- Cleared to 0 on every new grant.
- Increments on each tick and saturates at HOLD_TICKS.
- `hold_done` = (hold ≥ HOLD_TICKS).

FSM states:
- **IDLE**: gnt=000, led=000.
  - If req≠000, grant the lowest-index set bit: gnt=onehot, led=color of the winner, clear hold, go to OWNED.
- **OWNED**: led follows the owner's colour every cycle.
  - If the owner's req=1, stay in OWNED (preemption behaviour is set under Configuration).
  - If the owner's req=0 and hold_done=1, re-arbitrate in the same edge. Grant the lowest-index remaining req, with a fresh hold. If no req remains, go to IDLE with gnt=000 and led=000.
  - If the owner's req=0 and hold_done=0, go to LINGER: gnt=000, led keeps the last displayed colour.
- **LINGER**: no grant; led frozen.
  - When hold_done=1, arbitrate among the current req as in IDLE. If req=000, go to IDLE.
  - A requester re-raising req during LINGER gets no special claim; it competes normally at expiry.

Boundary conditions:
- Simultaneous requests: the lowest index always wins.
- Owner drop and a new request in the same cycle: the new request is handled by the same-edge re-arbitration.
- Because the prescaler is free-running, the actual hold time lies between (HOLD_TICKS-1)·TICK_DIV+1 and HOLD_TICKS·TICK_DIV cycles.
- Reset asserted mid-operation: all state clears immediately and asynchronously. No hold is honoured.

## Timing
Reset values:
- led=000, gnt=000, busy=0.
- State IDLE, prescaler=0, hold=0.

Latency:
- All outputs are registered.
- A req or colour change sampled at edge N is reflected on gnt, led and busy immediately after edge N (one-cycle latency from the input change).
- A grant is visible for at least one cycle.

Handshake:
- A requester may hold req high indefinitely.
- The grant is informational; requesters need not wait for gnt before changing colour.

## Configuration
Macro: LED_ARB_PREEMPT_EN.
- **Defined**: in OWNED with hold_done=1, a req bit of higher priority than the owner preempts it. On that edge, gnt switches to the higher-priority requester, led takes its colour and the hold restarts.
- **Undefined**: no preemption. The owner keeps the LED until it drops req.

## Test plan
All scenarios use TANG_NANO_HZ=100, TICK_HZ=10 (TICK_DIV=10) and HOLD_TICKS=3.
- **Reset**: assert rst at any time → led=000, gnt=000, busy=0 with no clock edge required.
- **Single grant and colour tracking**: req=010 with color1=101 → after the next edge gnt=010, led=101, busy=1. Change color1 to 011 → led=011 one edge later.
- **Simultaneous requests**: req=111 from IDLE with color0=001 → gnt=001, led=001.
- **Short request and LINGER**: req0 pulses for one cycle with color0=100 → gnt=001 for one cycle, then 000. led stays at 100 for 21 to 30 cycles, then led=000 and busy=0.
- **Preemption**: requester 2 owns the LED with hold_done=1, then req0 rises.
  - Without LED_ARB_PREEMPT_EN: gnt stays at 100.
  - With LED_ARB_PREEMPT_EN: gnt=001 and led=color0 after the next edge.
- **Reset during LINGER**: pulse rst while in LINGER → led=000 immediately. After rst is released with req=000, the block stays in IDLE.
